// File: rtl/ifb_pkg.sv
// Shared constants, entry type and width helpers for the instruction fetch buffer.
package ifb_pkg;

  localparam int IFB_ADDR_WIDTH  = 16;
  localparam int IFB_INSTR_WIDTH = 16;
  localparam int IFB_DEPTH       = 4;

  // One queued fetch: the instruction word and the address it was fetched from.
  typedef struct packed {
    logic [IFB_INSTR_WIDTH-1:0] instr;
    logic [IFB_ADDR_WIDTH-1:0]  pc;
  } ifb_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Generic DEPTH-entry FIFO: wrapping pointers, separate occupancy counter, synchronous clear.
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    r_count;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is reset so the head reads zero before the first push; clear leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = r_count;

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch buffer between PC/IMEM and decode: tracks the in-flight read, stalls the PC, flushes on redirect.
// Define IFB_BYPASS_EN to forward an IMEM response straight to decode when the buffer is empty.
module ifetch_buffer
  import ifb_pkg::*;
#(
  parameter int ADDR_WIDTH  = IFB_ADDR_WIDTH,
  parameter int INSTR_WIDTH = IFB_INSTR_WIDTH,
  parameter int DEPTH       = IFB_DEPTH
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_rstn,
  input  logic [ADDR_WIDTH-1:0]       i_pc,
  input  logic [INSTR_WIDTH-1:0]      i_imem_rdata,
  input  logic                        i_flush,
  output logic                        o_stall,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [INSTR_WIDTH-1:0]      o_instr,
  output logic [ADDR_WIDTH-1:0]       o_instr_pc,
  output logic [cnt_width(DEPTH)-1:0] o_count
);

  localparam int CW = cnt_width(DEPTH);
  localparam int EW = INSTR_WIDTH + ADDR_WIDTH;
  localparam logic [CW:0]   STALL_LVL = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic                  issue;
  logic                  resp_push;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [EW-1:0]         head;
  logic [CW-1:0]         count;
  logic [CW:0]           pending;

  // Queued plus in-flight; a pop this cycle is deliberately not credited.
  assign pending   = {1'b0, count} + {{CW{1'b0}}, r_inflight};
  assign o_stall   = !i_flush && (pending >= STALL_LVL);
  assign issue     = !o_stall && !i_flush;
  assign resp_push = r_inflight && !i_flush;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    fifo_push  = resp_push;
    o_valid    = (count != '0);
    o_instr    = head[EW-1:ADDR_WIDTH];
    o_instr_pc = head[ADDR_WIDTH-1:0];
`ifdef IFB_BYPASS_EN
    if ((count == '0) && resp_push) begin
      o_valid    = 1'b1;
      o_instr    = i_imem_rdata;
      o_instr_pc = r_inflight_pc;
      if (i_ready) fifo_push = 1'b0;
    end
`endif
    fifo_pop = (count != '0) && i_ready && !i_flush;
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rstn) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight    <= issue;
      r_inflight_pc <= i_pc;
    end
  end

  ifb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_sys_clk),
    .rst_n     (i_sys_rstn),
    .clear     (i_flush),
    .push      (fifo_push),
    .push_data ({i_imem_rdata, r_inflight_pc}),
    .pop       (fifo_pop),
    .head_data (head),
    .count     (count)
  );

  assign o_count = count;

  // The stall rule makes a net push into a full buffer impossible.
  a_no_push_on_full: assert property (
    @(posedge i_sys_clk) disable iff (!i_sys_rstn)
    !(fifo_push && !fifo_pop && (count == FULL_CNT))
  );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer: models PC register + synchronous IMEM, checks deliveries in order.
module tb_ifetch_buffer;
  import ifb_pkg::*;

  localparam int AW    = IFB_ADDR_WIDTH;
  localparam int IW    = IFB_INSTR_WIDTH;
  localparam int DEPTH = IFB_DEPTH;
  localparam int CW    = cnt_width(DEPTH);
`ifdef IFB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic [IW-1:0] rdata = '0;
  logic          stall;
  logic          valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  ifetch_buffer dut (
    .i_sys_clk    (clk),
    .i_sys_rstn   (rstn),
    .i_pc         (pc_in),
    .i_imem_rdata (rdata),
    .i_flush      (flush),
    .o_stall      (stall),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_instr      (instr),
    .o_instr_pc   (instr_pc),
    .o_count      (count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a ^ 16'hA5C3) + {a[7:0], a[15:8]};
  endfunction

  // Reference model: fetches issued and not yet killed or delivered, oldest first.
  ifb_entry_t    exp_q[$];
  logic          inflight_m = 1'b0;
  logic [AW-1:0] pc_reg = '0;
  logic [AW-1:0] reset_pc = '0;
  logic          last_rst = 1'b1;
  logic          last_flush = 1'b0;
  logic          last_issue = 1'b0;
  logic          last_stall = 1'b0;
  logic [AW-1:0] last_pc = '0;
  logic [AW-1:0] last_tgt = '0;
  int            cyc = 0;

  // Observations recorded by the monitor for the directed checks.
  logic          got_first = 1'b0;
  int            first_cyc = 0;
  logic [AW-1:0] first_pc = '0;
  logic          watch_on = 1'b0;
  logic          watch_got = 1'b0;
  logic [AW-1:0] watch_pc = '0;
  int            deliveries = 0;
  logic          stall_seen = 1'b0;

  // One clock cycle: apply the previous edge to the model, then drive this cycle's inputs.
  task automatic step(input logic rst_v, input logic flush_v, input logic ready_v,
                      input logic [AW-1:0] tgt);
    @(posedge clk);
    #1;
    cyc++;
    if (last_rst) begin
      exp_q.delete();
      inflight_m = 1'b0;
      pc_reg     = reset_pc;
    end else if (last_flush) begin
      exp_q.delete();
      inflight_m = 1'b0;
      pc_reg     = last_tgt;
    end else begin
      inflight_m = last_issue;
      if (last_issue) exp_q.push_back('{instr: mem_word(last_pc), pc: last_pc});
      if (!last_stall) pc_reg = pc_reg + 16'd1;
    end
    rdata = mem_word(last_pc);
    rstn  = rst_v;
    flush = flush_v;
    ready = ready_v;
    pc_in = pc_reg;
    #1;
    last_rst   = !rst_v;
    last_flush = rst_v && flush_v;
    last_tgt   = tgt;
    last_stall = stall;
    last_issue = rst_v && !stall && !flush_v;
    last_pc    = pc_reg;
    if (rst_v && stall) stall_seen = 1'b1;
  endtask

  task automatic do_reset(input logic [AW-1:0] start);
    reset_pc = start;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("reset_valid",    {31'b0, valid}, 32'd0);
    check("reset_stall",    {31'b0, stall}, 32'd0);
    check("reset_count",    32'(count),     32'd0);
    check("reset_instr",    32'(instr),     32'd0);
    check("reset_instr_pc", 32'(instr_pc),  32'd0);
    got_first  = 1'b0;
    stall_seen = 1'b0;
  endtask

  // Monitor: compares every handshake and the occupancy/stall against the model.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      check("stall_vs_model", {31'b0, stall},
            {31'b0, (!flush && (exp_q.size() >= DEPTH))});
      check("count_vs_model", 32'(count), 32'(exp_q.size() - int'(inflight_m)));
      check("count_le_depth", {31'b0, (int'(count) <= DEPTH)}, 32'd1);
      if (valid && ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: pc %0h delivered, nothing outstanding", instr_pc);
        end else begin
          ifb_entry_t e;
          e = exp_q.pop_front();
          check("deliver_pc",    32'(instr_pc), 32'(e.pc));
          check("deliver_instr", 32'(instr),    32'(e.instr));
          deliveries++;
          if (!got_first) begin
            got_first = 1'b1;
            first_cyc = cyc;
            first_pc  = instr_pc;
          end
          if (watch_on) begin
            watch_on  = 1'b0;
            watch_got = 1'b1;
            watch_pc  = instr_pc;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int rel_cyc;
    int fill_cnt[10]   = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};
    int fill_stall[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    // Linear fetch, decode always ready.
    do_reset(16'h0000);
    step(1'b1, 1'b0, 1'b1, '0);
    rel_cyc = cyc;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, '0);
    check("first_valid_latency", 32'(first_cyc - rel_cyc), 32'(LAT));
    check("first_pc",            32'(first_pc),            32'd0);
    check("linear_no_stall",     {31'b0, stall_seen},      32'd0);

    // Decode blocked: buffer fills to DEPTH, stall engages on count+inflight.
    do_reset(16'h0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      check("fill_count", 32'(count),       32'(fill_cnt[i]));
      check("fill_stall", {31'b0, stall},   32'(fill_stall[i]));
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, '0);

    // Buffer holds 5,6,7 with 8 in flight; redirect to 0x40.
    do_reset(16'h0005);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 16'h0040);
    check("flush_pre_count", 32'(count),     32'd3);
    check("flush_stall_low", {31'b0, stall}, 32'd0);
    watch_on  = 1'b1;
    watch_got = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0);
    check("flush_post_count", 32'(count),     32'd0);
    check("flush_post_valid", {31'b0, valid}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, '0);
    check("redirect_seen",    {31'b0, watch_got}, 32'd1);
    check("redirect_first_pc", 32'(watch_pc),     32'h40);

    // Flush while full and decode ready: flush wins over the pop.
    do_reset(16'h0100);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 16'h0200);
    check("full_flush_pre_count", 32'(count),     32'(DEPTH));
    check("full_flush_stall_low", {31'b0, stall}, 32'd0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("full_flush_count", 32'(count),     32'd0);
    check("full_flush_valid", {31'b0, valid}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, '0);

    // Random decode backpressure with occasional redirects.
    do_reset(16'h0000);
    deliveries = 0;
    for (int i = 0; i < 1000; i++) begin
      logic          f;
      logic [AW-1:0] t;
      f = ($urandom_range(0, 49) == 0);
      t = AW'($urandom_range(0, 16'hFFF0));
      step(1'b1, f, 1'($urandom_range(0, 1)), t);
    end
    check("random_progress", {31'b0, (deliveries > 200)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
